parity_window_ctrl: RTL

Controller and arbiter for the serial 3-bit-window parity detector. It accepts parallel words from two requesters with round-robin arbitration. Each accepted word is streamed bit-serially into the detector, LSB first. The controller samples the detector's Moore output after every bit and returns a vector of odd-parity flags, one per 3-bit window, to the winning requester over a valid/ready result port.

---
 rtl/parity_window_ctrl_pkg.sv | 17 +
 rtl/parity_window_ctrl_if.sv | 29 ++
 rtl/parity_window_ctrl_rr_arb2.sv | 30 +++
 rtl/parity_window_det.sv | 19 +
 rtl/parity_window_ctrl.sv | 103 ++++++++++
 5 files changed

// File: rtl/parity_window_ctrl_pkg.sv
// Shared types for the parity window controller: FSM state encoding and counter sizing.
// Combinational helpers only; no latency or backpressure of its own.
package parity_window_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bit counter must reach WIDTH-1 while still representing values up to WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/parity_window_ctrl_if.sv
// Requester, detector and result signals of the parity window controller.
// master = controller side, slave = requesters/consumer/detector side.
interface parity_window_ctrl_if #(parameter int WIDTH = 8);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             det_rst;
  logic             det_w;
  logic             det_z;
  logic             res_valid;
  logic [WIDTH-3:0] res_data;
  logic             res_src;
  logic             res_ready;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, det_z, res_ready,
    output req0_ready, req1_ready, det_rst, det_w, res_valid, res_data, res_src
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, det_z, res_ready,
    input  req0_ready, req1_ready, det_rst, det_w, res_valid, res_data, res_src
  );

endinterface

// File: rtl/parity_window_ctrl_rr_arb2.sv
// Two-way round-robin grant; combinational grant, last-served register updated on grant.
// Zero latency; grants only while en is high, loser stays pending for the next round.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       src
);

  logic last_src;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && req[1]) gnt = last_src ? 2'b01 : 2'b10;
      else                  gnt = req;
    end
  end

  assign src = gnt[1];

  // Resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_src <= 1'b1;
    else if (|gnt) last_src <= gnt[1];
  end

endmodule

// File: rtl/parity_window_det.sv
// Serial 3-bit-window parity detector: z is the XOR of the last three bits shifted in.
// One-cycle latency (registered history), no backpressure; rst clears history synchronously.
module parity_window_det (
  input  logic clk,
  input  logic rst,
  input  logic w,
  output logic z
);

  logic [2:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= '0;
    else     hist <= {hist[1:0], w};
  end

  assign z = ^hist;

endmodule

// File: rtl/parity_window_ctrl.sv
// Arbitrates two requesters, streams the won word LSB-first into the detector and returns sampled window parities.
// Result valid WIDTH+1 cycles after handshake; DONE holds until res_ready, requesters see ready=0 meanwhile.
module parity_window_ctrl
  import parity_window_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  parity_window_ctrl_if.master bus
);

  localparam int RW = WIDTH - 2;
  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [RW-1:0]    res_data_q;
  logic             res_src_q;
  logic             res_valid_q;
  logic             det_rst_q;
  logic             det_w_q;

  logic [1:0]       gnt;
  logic             gnt_src;
  logic [WIDTH-1:0] gnt_data;
  logic             arb_en;

  assign arb_en = (state == IDLE) && !rst;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({bus.req1_valid, bus.req0_valid}),
    .gnt (gnt),
    .src (gnt_src)
  );

  assign gnt_data = gnt_src ? bus.req1_data : bus.req0_data;

  // shreg holds the bits not yet presented; det_w is registered one bit ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      res_data_q  <= '0;
      res_src_q   <= 1'b0;
      res_valid_q <= 1'b0;
      det_rst_q   <= 1'b1;
      det_w_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            state     <= SHIFT;
            shreg     <= gnt_data >> 1;
            det_w_q   <= gnt_data[0];
            det_rst_q <= 1'b0;
            res_src_q <= gnt_src;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          // Windows complete in order, so shifting in from the top lands window j at bit j.
          if (cnt >= CW'(3)) res_data_q <= (res_data_q >> 1) | (RW'(bus.det_z) << (RW - 1));
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state   <= DRAIN;
            det_w_q <= 1'b0;
          end else begin
            det_w_q <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        DRAIN: begin
          res_data_q  <= (res_data_q >> 1) | (RW'(bus.det_z) << (RW - 1));
          state       <= DONE;
          res_valid_q <= 1'b1;
          det_rst_q   <= 1'b1;
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.det_rst    = det_rst_q;
  assign bus.det_w      = det_w_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_src    = res_src_q;

endmodule
